// File: rtl/pll_reset_sequencer_if.sv
// rtl/pll_reset_sequencer_if.sv - lock/reset signal bundle between PLL sequencer and its surroundings
interface pll_reset_sequencer_if;
    logic       locked;
    logic       sw_reset_req;
    logic       rst_out;
    logic       ready;
    logic [7:0] lock_loss_cnt;
    logic [1:0] state;

    // master: the sequencer itself; slave: the PLL/software side feeding it
    modport master (
        input  locked,
        input  sw_reset_req,
        output rst_out,
        output ready,
        output lock_loss_cnt,
        output state
    );

    modport slave (
        output locked,
        output sw_reset_req,
        input  rst_out,
        input  ready,
        input  lock_loss_cnt,
        input  state
    );
endinterface

// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - qualifies PLL lock then sequences downstream reset release
module pll_reset_sequencer #(
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int RST_HOLD_CYCLES    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    pll_reset_sequencer_if.master bus
);
    localparam int MAX_CYCLES = (LOCK_STABLE_CYCLES > RST_HOLD_CYCLES) ?
                                LOCK_STABLE_CYCLES : RST_HOLD_CYCLES;
    localparam int CNT_W = $clog2(MAX_CYCLES) + 1;
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RST_HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync;
    logic                   lk_s;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   loss_inc;
    logic                   rst_out_q, ready_q;
    logic [7:0]             loss_q;

    assign lk_s = sync[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], bus.locked};
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        loss_inc = 1'b0;
        case (state_q)
            WAIT_LOCK: begin
                if (lk_s) state_d = STABLE;
            end
            STABLE: begin
                if (!lk_s)                     state_d = WAIT_LOCK;
                else if (cnt_q == STABLE_LAST) state_d = HOLD;
                else                           cnt_d   = cnt_q + 1'b1;
            end
            HOLD: begin
                if (!lk_s)                   state_d = WAIT_LOCK;
                else if (cnt_q == HOLD_LAST) state_d = RUN;
                else                         cnt_d   = cnt_q + 1'b1;
            end
            RUN: begin
                // lock loss takes priority over a software request in the same cycle
                if (!lk_s) begin
                    state_d  = WAIT_LOCK;
                    loss_inc = 1'b1;
                end else if (bus.sw_reset_req) begin
                    state_d = HOLD;
                end
            end
            default: state_d = WAIT_LOCK;
        endcase
        if (state_d != state_q) cnt_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= WAIT_LOCK;
            cnt_q     <= '0;
            rst_out_q <= 1'b1;
            ready_q   <= 1'b0;
            loss_q    <= 8'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rst_out_q <= (state_d != RUN);
            ready_q   <= (state_d == RUN);
            if (loss_inc && (loss_q != 8'hFF)) loss_q <= loss_q + 8'd1;
        end
    end

    assign bus.rst_out       = rst_out_q;
    assign bus.ready         = ready_q;
    assign bus.state         = state_q;
    assign bus.lock_loss_cnt = loss_q;
endmodule
